// File: rtl/dpram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_fifo_ctrl_if
//  Brief    : Bundle of user-side FIFO handshake/status signals and the
//             dual-port RAM port signals driven by dpram_fifo_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface dpram_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    // User side
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    // RAM side
    logic              ram_w1;
    logic [ADDR_W-1:0] ram_addr1;
    logic [DATA_W-1:0] ram_d1;
    logic              ram_w2;
    logic [ADDR_W-1:0] ram_addr2;
    logic [DATA_W-1:0] ram_dout2;

    // Environment view: drives requests and the RAM read data
    modport master (
        output wr_en, wr_data, rd_en, clr_err, ram_dout2,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow,
               ram_w1, ram_addr1, ram_d1, ram_w2, ram_addr2
    );

    // Controller view
    modport slave (
        input  wr_en, wr_data, rd_en, clr_err, ram_dout2,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow,
               ram_w1, ram_addr1, ram_d1, ram_w2, ram_addr2
    );
endinterface
`default_nettype wire

// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_fifo_ctrl
//  Brief    : FIFO controller wrapping an external dual-port RAM (port 1 write,
//             port 2 registered read). Owns pointers, occupancy, status and
//             sticky error flags, and qualifies RAM read data with rd_valid.
//  Revision : 1.0  initial release
// ============================================================================
module dpram_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    dpram_fifo_ctrl_if.slave bus
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] c_AF    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] c_AE    = (ADDR_W+1)'(AE_LEVEL);

    // Pointers carry one extra wrap bit above the RAM address
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q,  count_d;
    logic            full_q,   full_d;
    logic            empty_q,  empty_d;
    logic            afull_q,  afull_d;
    logic            aempty_q, aempty_d;
    logic            rvalid_q;
    logic            ovf_q,    ovf_d;
    logic            unf_q,    unf_d;

    logic            w_wr_acc;
    logic            w_rd_acc;

    // Accept logic, pointer/count advance, next flag values and sticky errors
    always_comb begin
        w_wr_acc = bus.wr_en & ~full_q;
        w_rd_acc = bus.rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(w_wr_acc);
        rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(w_rd_acc);
        count_d  = count_q + (ADDR_W+1)'(w_wr_acc) - (ADDR_W+1)'(w_rd_acc);
        full_d   = (count_d == c_DEPTH);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= c_AF);
        aempty_d = (count_d <= c_AE);
        // A new error event in the same cycle as clr_err keeps the flag set
        ovf_d    = (bus.wr_en & full_q)  | (ovf_q & ~bus.clr_err);
        unf_d    = (bus.rd_en & empty_q) | (unf_q & ~bus.clr_err);
    end

    // State registers; rd_valid follows the read accept by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            rvalid_q <= w_rd_acc;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // RAM write port; gated by rst_n so no write can slip through in reset
    assign bus.ram_w1    = w_wr_acc & rst_n;
    assign bus.ram_addr1 = wr_ptr_q[ADDR_W-1:0];
    assign bus.ram_d1    = bus.wr_data[DATA_W-1:0];

    // RAM read port always presents the current read pointer
    assign bus.ram_w2    = 1'b0;
    assign bus.ram_addr2 = rd_ptr_q[ADDR_W-1:0];

    // User-facing outputs
    assign bus.rd_data      = bus.ram_dout2[DATA_W-1:0];
    assign bus.rd_valid     = rvalid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule
`default_nettype wire
